// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and round-robin pick for the Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Returns 1 when master 1 should be granted; under contention the master
    // that was not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

endpackage

// File: rtl/wb_arb_cnt.sv
// rtl/wb_arb_cnt.sv - saturating-safe up/down transaction counter with load and clear
// Ports: clk, rst (sync, active-low), clr, load/load_val, inc, dec -> cnt, full, zero, err
module wb_arb_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         zero,
    output logic         err
);

    logic dec_ok;

    assign full   = (cnt == W'(MAX));
    assign zero   = (cnt == '0);
    // A decrement with nothing counted is refused and reported.
    assign err    = dec & zero;
    assign dec_ok = dec & ~zero;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && !dec_ok) begin
            cnt <= cnt + W'(1);
        end else if (!inc && dec_ok) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin arbiter for pipelined Wishbone with cycle locking
// Ports: clk, rst (sync, active-low); m0_*/m1_* master ports (cyc, stb, we, adr, dat_i -> dat_o, ack, stall);
//        s_* slave port (cyc, stb, we, adr, dat_o -> dat_i, ack, stall)
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack,
    output logic          m0_stall,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    input  logic          s_stall
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    arb_state_t       state;
    logic             last;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] drn_cnt;
    logic [CNT_W-1:0] drn_rem;
    logic             out_full, out_zero, out_err;
    logic             drn_full, drn_zero, drn_err;
    logic             drain;
    logic             g0, g1;
    logic             cyc_exit;
    logic             issue;
    logic             ack_live;
    logic             unused_drn_full;

    assign unused_drn_full = drn_full;

    // Granted-and-still-in-cycle; reset gates the bus immediately.
    assign g0 = rst & (state == GNT0) & m0_cyc;
    assign g1 = rst & (state == GNT1) & m1_cyc;

    assign cyc_exit = rst & (((state == GNT0) & ~m0_cyc) | ((state == GNT1) & ~m1_cyc));

    // Leftover acks from an aborted cycle belong to nobody.
    assign drain    = ~drn_zero;
    assign ack_live = s_ack & ~drain & ~out_zero;
    assign issue    = s_cyc & s_stb & ~s_stall;
    // Acks landing on the exit cycle itself are already part of the drain.
    assign drn_rem  = out_cnt - CNT_W'(ack_live);

    assign s_cyc   = g0 | g1;
    assign s_stb   = ((g0 & m0_stb) | (g1 & m1_stb)) & ~out_full & ~drain;
    assign s_we    = g1 ? m1_we    : m0_we;
    assign s_adr   = g1 ? m1_adr   : m0_adr;
    assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;

    // Stalling during drain keeps the new owner's strobe pending, not lost.
    assign m0_stall = g0 ? (s_stall | out_full | drain) : m0_stb;
    assign m1_stall = g1 ? (s_stall | out_full | drain) : m1_stb;
    assign m0_ack   = g0 & ack_live;
    assign m1_ack   = g1 & ack_live;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_arb_cnt #(.MAX(MAX_OUT), .W(CNT_W)) u_out_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cyc_exit),
        .load     (1'b0),
        .load_val ('0),
        .inc      (issue),
        .dec      (s_ack & ~drain),
        .cnt      (out_cnt),
        .full     (out_full),
        .zero     (out_zero),
        .err      (out_err)
    );

    wb_arb_cnt #(.MAX(MAX_OUT), .W(CNT_W)) u_drn_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (cyc_exit & (drn_rem != '0)),
        .load_val (drn_rem),
        .inc      (1'b0),
        .dec      (s_ack & drain),
        .cnt      (drn_cnt),
        .full     (drn_full),
        .zero     (drn_zero),
        .err      (drn_err)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc || m1_cyc) begin
                        state <= rr_pick(m0_cyc, m1_cyc, last) ? GNT1 : GNT0;
                    end
                end
                GNT0: begin
                    if (!m0_cyc) begin
                        last  <= 1'b0;
                        state <= m1_cyc ? GNT1 : IDLE;
                    end
                end
                GNT1: begin
                    if (!m1_cyc) begin
                        last  <= 1'b1;
                        state <= m0_cyc ? GNT0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(out_err | drn_err))
        else $error("wb_arbiter2: s_ack with no outstanding transaction");

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed self-checking bench for wb_arbiter2
module tb_wb_arbiter2;
    import wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [15:0] m0_adr, m0_dat_i, m0_dat_o;
    logic        m0_ack, m0_stall;
    logic        m1_cyc, m1_stb, m1_we;
    logic [15:0] m1_adr, m1_dat_i, m1_dat_o;
    logic        m1_ack, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [15:0] s_adr, s_dat_o, s_dat_i;
    logic        s_ack, s_stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(16), .DW(16), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .s_stall(s_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 16'h0; m0_dat_i = 16'h0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 16'h0; m1_dat_i = 16'h0;
        s_dat_i = 16'h0; s_ack = 0; s_stall = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        step();
        step();
        m0_cyc = 1; m0_stb = 1;
        #1;
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        n_cmp++; if (dut.last !== 1'b1) begin n_bad++; $display("FAIL reset_last: got %b want 1", dut.last); end
        n_cmp++; if (dut.out_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_out_cnt: got %0d want 0", dut.out_cnt); end
        n_cmp++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_bad++; $display("FAIL reset_s_cyc_stb: got %b%b want 00", s_cyc, s_stb); end
        n_cmp++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_bad++; $display("FAIL reset_acks: got %b%b want 00", m0_ack, m1_ack); end
        n_cmp++; if (m0_stall !== 1'b1 || m1_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b%b want 10", m0_stall, m1_stall); end
        step();
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_hold_state: got %0d want %0d", dut.state, IDLE); end
        idle_inputs();
        rst = 1;
        step();
    endtask

    task automatic test_contention();
        m0_cyc = 1; m1_cyc = 1;
        #1;
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL cont_idle_s_cyc: got %b want 0", s_cyc); end
        step();
        n_cmp++; if (dut.state !== GNT0) begin n_bad++; $display("FAIL cont_first_gnt: got %0d want %0d", dut.state, GNT0); end
        n_cmp++; if (s_cyc !== 1'b1) begin n_bad++; $display("FAIL cont_gnt0_s_cyc: got %b want 1", s_cyc); end
        m0_cyc = 0;
        #1;
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL cont_exit_s_cyc: got %b want 0", s_cyc); end
        step();
        n_cmp++; if (dut.state !== GNT1) begin n_bad++; $display("FAIL cont_handoff: got %0d want %0d", dut.state, GNT1); end
        n_cmp++; if (s_cyc !== 1'b1) begin n_bad++; $display("FAIL cont_gnt1_s_cyc: got %b want 1", s_cyc); end
        m1_cyc = 0;
        step();
        n_cmp++; if (dut.state !== IDLE || dut.last !== 1'b1) begin n_bad++; $display("FAIL cont_end: got state %0d last %b want 0 1", dut.state, dut.last); end
    endtask

    task automatic test_single_read();
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0010;
        #1;
        n_cmp++; if (m0_stall !== 1'b1 || s_cyc !== 1'b0) begin n_bad++; $display("FAIL rd_idle: got stall %b s_cyc %b want 1 0", m0_stall, s_cyc); end
        step();
        n_cmp++; if (dut.state !== GNT0) begin n_bad++; $display("FAIL rd_grant: got %0d want %0d", dut.state, GNT0); end
        n_cmp++; if (s_cyc !== 1'b1 || s_stb !== 1'b1 || m0_stall !== 1'b0) begin n_bad++; $display("FAIL rd_issue: got cyc %b stb %b stall %b want 1 1 0", s_cyc, s_stb, m0_stall); end
        n_cmp++; if (s_adr !== 16'h0010) begin n_bad++; $display("FAIL rd_adr: got %h want 0010", s_adr); end
        step();
        m0_stb = 0; s_ack = 1; s_dat_i = 16'hBEEF;
        #1;
        n_cmp++; if (dut.out_cnt !== 3'd1) begin n_bad++; $display("FAIL rd_out_cnt: got %0d want 1", dut.out_cnt); end
        n_cmp++; if (m0_ack !== 1'b1 || m0_dat_o !== 16'hBEEF) begin n_bad++; $display("FAIL rd_ack: got %b %h want 1 beef", m0_ack, m0_dat_o); end
        n_cmp++; if (m1_ack !== 1'b0) begin n_bad++; $display("FAIL rd_m1_ack: got %b want 0", m1_ack); end
        step();
        s_ack = 0; m0_cyc = 0;
        #1;
        n_cmp++; if (dut.out_cnt !== 3'd0) begin n_bad++; $display("FAIL rd_out_cnt_end: got %0d want 0", dut.out_cnt); end
        step();
        n_cmp++; if (dut.state !== IDLE || dut.last !== 1'b0) begin n_bad++; $display("FAIL rd_end: got state %0d last %b want 0 0", dut.state, dut.last); end
    endtask

    task automatic test_round_robin();
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1;
        step();
        n_cmp++; if (dut.state !== GNT1) begin n_bad++; $display("FAIL rr_grant: got %0d want %0d", dut.state, GNT1); end
        n_cmp++; if (m0_stall !== 1'b1 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL rr_loser: got stall %b ack %b want 1 0", m0_stall, m0_ack); end
        idle_inputs();
        step();
        n_cmp++; if (dut.state !== IDLE || dut.last !== 1'b1) begin n_bad++; $display("FAIL rr_end: got state %0d last %b want 0 1", dut.state, dut.last); end
    endtask

    task automatic test_pipeline_full();
        int issued = 0;
        int acked = 0;
        int obs_issue = 0;
        int obs_ack = 0;
        int exp_out = 0;
        int issue_at[6];
        logic exp_issue;
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0100;
        step();
        for (int c = 1; c < 30; c++) begin
            m0_stb = (issued < 6);
            s_ack  = (acked < issued) && (c == issue_at[acked] + 5);
            #1;
            n_cmp++; if (m0_stall !== (exp_out == 4)) begin n_bad++; $display("FAIL pipe_stall c%0d: got %b want %b", c, m0_stall, exp_out == 4); end
            exp_issue = m0_stb && (exp_out < 4);
            if (s_cyc && s_stb && !s_stall) obs_issue++;
            if (m0_ack) obs_ack++;
            if (exp_issue) begin issue_at[issued] = c; issued++; end
            exp_out = exp_out + (exp_issue ? 1 : 0) - (s_ack ? 1 : 0);
            if (s_ack) acked++;
            step();
            if (acked == 6) break;
        end
        s_ack = 0; m0_stb = 0;
        #1;
        n_cmp++; if (obs_issue !== 6) begin n_bad++; $display("FAIL pipe_issues: got %0d want 6", obs_issue); end
        n_cmp++; if (obs_ack !== 6) begin n_bad++; $display("FAIL pipe_acks: got %0d want 6", obs_ack); end
        n_cmp++; if (dut.out_cnt !== 3'd0) begin n_bad++; $display("FAIL pipe_out_cnt: got %0d want 0", dut.out_cnt); end
        m0_cyc = 0;
        step();
    endtask

    task automatic test_abort_drain();
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0200;
        step();
        step();
        step();
        s_ack = 1; s_dat_i = 16'h1111;
        #1;
        n_cmp++; if (m0_ack !== 1'b1) begin n_bad++; $display("FAIL drn_first_ack: got %b want 1", m0_ack); end
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        m1_cyc = 1; m1_stb = 1; m1_adr = 16'h0300;
        #1;
        n_cmp++; if (dut.out_cnt !== 3'd2) begin n_bad++; $display("FAIL drn_out_cnt: got %0d want 2", dut.out_cnt); end
        n_cmp++; if (s_cyc !== 1'b0 || m1_stall !== 1'b1) begin n_bad++; $display("FAIL drn_exit: got cyc %b stall %b want 0 1", s_cyc, m1_stall); end
        step();
        for (int k = 0; k < 2; k++) begin
            s_ack = 1; s_dat_i = 16'hDEAD;
            #1;
            n_cmp++; if (m1_ack !== 1'b0 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL drn_late_ack%0d: got %b%b want 00", k, m1_ack, m0_ack); end
            n_cmp++; if (s_cyc !== 1'b1 || s_stb !== 1'b0 || m1_stall !== 1'b1) begin n_bad++; $display("FAIL drn_hold%0d: got cyc %b stb %b stall %b want 1 0 1", k, s_cyc, s_stb, m1_stall); end
            step();
        end
        s_ack = 0;
        #1;
        n_cmp++; if (s_stb !== 1'b1 || m1_stall !== 1'b0 || s_adr !== 16'h0300) begin n_bad++; $display("FAIL drn_resume: got stb %b stall %b adr %h want 1 0 0300", s_stb, m1_stall, s_adr); end
        step();
        m1_stb = 0; s_ack = 1; s_dat_i = 16'h1234;
        #1;
        n_cmp++; if (m1_ack !== 1'b1 || m1_dat_o !== 16'h1234 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL drn_m1_read: got %b %h %b want 1 1234 0", m1_ack, m1_dat_o, m0_ack); end
        step();
        idle_inputs();
        step();
        n_cmp++; if (dut.state !== IDLE || dut.out_cnt !== 3'd0) begin n_bad++; $display("FAIL drn_end: got state %0d cnt %0d want 0 0", dut.state, dut.out_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        m1_cyc = 1; m1_stb = 1; m1_adr = 16'h0400;
        step();
        step();
        step();
        m1_stb = 0;
        #1;
        n_cmp++; if (dut.state !== GNT1 || dut.out_cnt !== 3'd2) begin n_bad++; $display("FAIL rstm_setup: got state %0d cnt %0d want 2 2", dut.state, dut.out_cnt); end
        rst = 0;
        #1;
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL rstm_s_cyc: got %b want 0", s_cyc); end
        step();
        n_cmp++; if (dut.state !== IDLE || dut.out_cnt !== 3'd0) begin n_bad++; $display("FAIL rstm_clear: got state %0d cnt %0d want 0 0", dut.state, dut.out_cnt); end
        for (int k = 0; k < 2; k++) begin
            s_ack = 1;
            #1;
            n_cmp++; if (m1_ack !== 1'b0 || s_cyc !== 1'b0) begin n_bad++; $display("FAIL rstm_ack%0d: got ack %b cyc %b want 0 0", k, m1_ack, s_cyc); end
            step();
        end
        s_ack = 0; rst = 1;
        m0_cyc = 1; m1_cyc = 1;
        step();
        n_cmp++; if (dut.state !== GNT0) begin n_bad++; $display("FAIL rstm_regrant: got %0d want %0d", dut.state, GNT0); end
        idle_inputs();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_contention();
        test_single_read();
        test_round_robin();
        test_pipeline_full();
        test_abort_drain();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave arbiter for classic pipelined Wishbone (cyc/stb/stall/ack).
- Shares a single slave, e.g. the instruction/data ROM, between the J1 instruction-fetch port (m0) and the data port (m1).
- Uses round-robin with bus-cycle locking: a granted master keeps the slave until it drops cyc.
- Counts outstanding transactions so every ack returns to its issuer and pipelining stays bounded.

Parameters:
- AW, 16: address width.
- DW, 16: data width.
- MAX_OUT, 4: maximum outstanding (issued, un-acked) transactions; power of two, ≥1.

Ports:
- clk, in, 1: bus clock.
- rst, in, 1: synchronous reset, active-low (0 = reset).
- m0_cyc, m0_stb, m0_we, in, 1 each: master 0 cycle, strobe, write enable.
- m0_adr, in, AW: master 0 address.
- m0_dat_i, in, DW: master 0 write data.
- m0_dat_o, out, DW: read data to master 0.
- m0_ack, m0_stall, out, 1 each: acknowledge and stall to master 0.
- m1_* : identical set for master 1.
- s_cyc, s_stb, s_we, out, 1 each: slave cycle, strobe, write enable.
- s_adr, out, AW: slave address.
- s_dat_o, out, DW: write data to the slave.
- s_dat_i, in, DW: read data from the slave.
- s_ack, s_stall, in, 1 each: slave acknowledge and stall.

Behaviour:
- State register: IDLE, GNT0, GNT1. Also a last-served pointer `last` (1 bit) and an outstanding counter `out_cnt` (0..MAX_OUT).
- Reset (rst==0 at posedge): state=IDLE, last=1 (m0 wins the first contention), out_cnt=0.
- Output values in reset and IDLE: s_cyc=s_stb=0, m0_ack=m1_ack=0. mX_stall = mX_stb (stall any strobe not granted).
- IDLE transitions (registered grant, one arbitration cycle):
  - Only m0_cyc → GNT0.
  - Only m1_cyc → GNT1.
  - Both → grant the master != last.
  - Neither → stay IDLE.
- GNTx, while mx_cyc=1:
  - Forwarding: s_cyc=1; s_stb = mx_stb & (out_cnt<MAX_OUT); s_we/s_adr/s_dat_o = mx_*.
  - mx_stall = s_stall | (out_cnt==MAX_OUT).
  - mx_ack = s_ack; mx_dat_o = s_dat_i.
- Non-granted master in GNTx: stall = its stb, ack=0.
- Both mX_dat_o always carry s_dat_i; only ack qualifies the data.
- GNTx exit, on a cycle where mx_cyc=0:
  - s_cyc=0 combinationally.
  - last<=x.
  - out_cnt<=0.
  - Next state = GNTy if my_cyc=1 (direct handoff, no dead cycle), else IDLE.
- Issue count: issue = s_cyc & s_stb & ~s_stall.
- Counter update: out_cnt <= out_cnt + issue - s_ack.
  - Simultaneous issue and ack leaves it unchanged.
  - At MAX_OUT, no issue is possible, so there is no overflow.
- Underflow: s_ack with out_cnt==0 is a slave protocol error. The ack is not forwarded and out_cnt stays 0. A simulation-only assertion flags it.
- Aborted cycle: master drops cyc while out_cnt>0. Pending acks still arriving from the slave are discarded and never routed to the new owner. A 1-bit `drain` flag, plus a drain counter loaded from out_cnt, suppresses acks until drained.
  - A new grant may begin during drain.
  - s_stb for the new owner is held 0 until drain completes.
- Latency:
  - Grant from IDLE: 1 clock after cyc.
  - Data path: combinational pass-through, zero added latency.
- rst asserted mid-transfer: all state clears next edge. s_cyc=0 and any in-flight ack is ignored.
- Write-only and read-only cycles are treated identically; the arbiter never inspects we.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t.
  - function for the round-robin pick.
  - localparam CNT_W = $clog2(MAX_OUT+1) computed in the module.
- Sub-module wb_arb_cnt: outstanding/drain counter with inc, dec, load, full, zero, err outputs. Reused by a future N-master arbiter.

Test Plan:
- Single master read: m0 reads adr 0x0010 (cyc/stb 1 clk), slave acks 1 clk later with 0xBEEF → GNT0 one clk after cyc; m0_ack=1 and m0_dat_o=0xBEEF one clk after issue; m1_ack stays 0.
- Contention after reset: m0_cyc and m1_cyc rise in the same cycle → GNT0 first. When m0 drops cyc with m1 still requesting, GNT1 follows on the next edge with no IDLE cycle.
- Round-robin: m0 completes a cycle, both then request simultaneously from IDLE → GNT1 (last=0).
- Pipelining/full: MAX_OUT=4, m0 issues 6 back-to-back strobes, slave acks after 5 clks → m0_stall=1 once out_cnt=4. Exactly 6 issues and 6 acks; out_cnt returns to 0.
- Abort/drain: m0 issues 3, drops cyc after 1 ack, m1 requests → 2 late acks are not forwarded to m1. m1's s_stb is held 0 until drained, then m1's read completes normally.
- Reset mid-burst: rst=0 while GNT1 with out_cnt=2 → next clk state=IDLE, s_cyc=0, out_cnt=0. After rst=1, m0 is granted first under contention.
